// File: rtl/uart_txrx.sv
`default_nettype none
// ============================================================================
// Module      : uart_txrx
// Description : Single-clock 8N1 UART. Independent transmitter and receiver
//               sharing clock and reset; bit time set by CLKS_PER_BIT.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_txrx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int                 CNT_W     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   MID_START = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP
  } rx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_serial_q, tx_serial_d;
  logic             tx_active_q, tx_active_d;
  logic             tx_done_q, tx_done_d;

  // TX state register; reset aborts any frame and returns the line to idle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_data_q   <= '0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_data_q   <= tx_data_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // TX next state: the line value is registered one edge ahead, so each bit
  // occupies exactly CLKS_PER_BIT clocks starting at the accepting edge.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_data_d   = tx_data_q;
    tx_serial_d = tx_serial_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_serial_d = 1'b1;
        tx_cnt_d    = '0;
        tx_idx_d    = '0;
        if (i_TX_DV) begin
          tx_data_d   = i_TX_Byte;
          tx_state_d  = TX_START;
          tx_active_d = 1'b1;
          tx_serial_d = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = TX_DATA;
          tx_serial_d = tx_data_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d  = TX_STOP;
            tx_serial_d = 1'b1;
          end else begin
            tx_idx_d    = tx_idx_q + 3'd1;
            tx_serial_d = tx_data_q[tx_idx_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_done_d   = 1'b1;
          tx_active_d = 1'b0;
          tx_state_d  = TX_CLEANUP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_CLEANUP: tx_state_d = TX_IDLE;
      default:    tx_state_d = TX_IDLE;
    endcase
  end

  assign o_TX_Serial = tx_serial_q;
  assign o_TX_Active = tx_active_q;
  assign o_TX_Done   = tx_done_q;

  // ---------------------------------------------------------------- RX path
  logic             rx_meta_q, rx_sync_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_dv_q, rx_dv_d;

  // Two-flop synchronizer for the asynchronous line (idles high).
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX state register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  // RX next state: qualify the start bit at its midpoint, then sample every
  // bit time so all later samples land mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == MID_START) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_sync_q;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_CLEANUP;
          if (rx_sync_q) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      // Hold here while the line stays low so a break cannot retrigger.
      RX_CLEANUP: if (rx_sync_q) rx_state_d = RX_IDLE;
      default:    rx_state_d = RX_IDLE;
    endcase
  end

  assign o_RX_DV   = rx_dv_q;
  assign o_RX_Byte = rx_byte_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_txrx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_txrx
// Description : Directed self-checking bench for uart_txrx (loopback and
//               bench-driven RX line).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_txrx;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_TX_DV = 1'b0;
  logic [7:0] i_TX_Byte = 8'h00;
  logic       o_TX_Active, o_TX_Serial, o_TX_Done;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;

  logic loop_en  = 1'b1;
  logic rx_drive = 1'b1;

  assign i_RX_Serial = loop_en ? (o_TX_Active ? o_TX_Serial : 1'b1) : rx_drive;

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Reset    (i_Reset),
    .i_TX_DV    (i_TX_DV),
    .i_TX_Byte  (i_TX_Byte),
    .o_TX_Active(o_TX_Active),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Done  (o_TX_Done),
    .i_RX_Serial(i_RX_Serial),
    .o_RX_DV    (o_RX_DV),
    .o_RX_Byte  (o_RX_Byte)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] rx_bytes[$];

  // Pulse monitors, sampled on the inactive edge.
  always @(negedge clk) begin
    if (o_RX_DV) begin
      rx_cnt = rx_cnt + 1;
      rx_bytes.push_back(o_RX_Byte);
    end
    if (o_TX_Done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_TX_Byte = b;
    i_TX_DV   = 1'b1;
    @(negedge clk);
    i_TX_DV   = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    int n = 0;
    while (rx_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rx_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drive = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drive = 1'b1;
  endtask

  initial begin
    int         base_rx;
    int         base_done;
    int         lat;
    int         bit_err;
    int         act_err;
    logic [9:0] frame;
    logic [7:0] pats[3];

    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst_tx_serial", 32'(o_TX_Serial), 32'd1);
    check("rst_tx_active", 32'(o_TX_Active), 32'd0);
    check("rst_tx_done",   32'(o_TX_Done),   32'd0);
    check("rst_rx_dv",     32'(o_RX_DV),     32'd0);
    check("rst_rx_byte",   32'(o_RX_Byte),   32'h00);
    i_Reset = 1'b0;
    @(negedge clk);

    // ---- loopback 0x3F with latency measurement
    send(8'h3F);
    lat = 0;
    while (!o_RX_DV && lat < 2200) begin
      @(negedge clk);
      lat++;
    end
    check("lb_latency_ok", 32'(lat >= 2063 && lat <= 2070), 32'd1);
    wait_done(1, 300, "lb_done_timeout");
    repeat (20) @(negedge clk);
    check("lb_rx_count", 32'(rx_cnt), 32'd1);
    check("lb_rx_byte", 32'(o_RX_Byte), 32'h3F);
    check("lb_done_count", 32'(done_cnt), 32'd1);

    // ---- bit timing 0xA5: start, 1,0,1,0,0,1,0,1, stop
    repeat (5) @(negedge clk);
    check("bt_idle_line", 32'(o_TX_Serial), 32'd1);
    send(8'hA5);
    frame = {1'b1, 8'hA5, 1'b0};
    act_err = 0;
    for (int b = 0; b < 10; b++) begin
      bit_err = 0;
      for (int k = 0; k < CPB; k++) begin
        if (o_TX_Serial !== frame[b]) bit_err++;
        if (o_TX_Active !== 1'b1) act_err++;
        @(negedge clk);
      end
      check($sformatf("bt_bit%0d_errs", b), 32'(bit_err), 32'd0);
    end
    check("bt_active_errs", 32'(act_err), 32'd0);
    check("bt_active_end", 32'(o_TX_Active), 32'd0);
    check("bt_done_end", 32'(o_TX_Done), 32'd1);
    repeat (5) @(negedge clk);
    check("bt_rx_byte", 32'(o_RX_Byte), 32'hA5);

    // ---- back-to-back patterns, each issued the cycle after Done
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h55;
    base_rx   = rx_cnt;
    base_done = done_cnt;
    repeat (5) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      send(pats[p]);
      wait_done(base_done + p + 1, 2300, "b2b_done_timeout");
    end
    repeat (20) @(negedge clk);
    check("b2b_rx_count", 32'(rx_cnt - base_rx), 32'd3);
    for (int p = 0; p < 3; p++) begin
      if (rx_bytes.size() > base_rx + p)
        check($sformatf("b2b_byte%0d", p), 32'(rx_bytes[base_rx + p]), 32'(pats[p]));
      else
        check($sformatf("b2b_byte%0d_missing", p), 32'd0, 32'd1);
    end

    // ---- busy-ignore: 0x12 strobed mid-frame of 0x34
    base_rx   = rx_cnt;
    base_done = done_cnt;
    send(8'h34);
    repeat (1000) @(negedge clk);
    send(8'h12);
    wait_done(base_done + 1, 2000, "busy_done_timeout");
    repeat (50) @(negedge clk);
    check("busy_tx_active", 32'(o_TX_Active), 32'd0);
    check("busy_done_count", 32'(done_cnt - base_done), 32'd1);
    check("busy_rx_count", 32'(rx_cnt - base_rx), 32'd1);
    check("busy_rx_byte", 32'(o_RX_Byte), 32'h34);

    // ---- RX glitch: 50-clock low pulse
    loop_en = 1'b0;
    base_rx = rx_cnt;
    rx_drive = 1'b0;
    repeat (50) @(negedge clk);
    rx_drive = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_no_dv", 32'(rx_cnt - base_rx), 32'd0);

    // ---- framing error: 0x81 with stop bit 0
    drive_frame(8'h81, 1'b0);
    repeat (300) @(negedge clk);
    check("frame_err_no_dv", 32'(rx_cnt - base_rx), 32'd0);
    check("frame_err_byte_held", 32'(o_RX_Byte), 32'h34);

    // ---- receiver recovered: good driven frame 0x5A
    drive_frame(8'h5A, 1'b1);
    wait_rx(base_rx + 1, 300, "drv_rx_timeout");
    check("drv_rx_byte", 32'(o_RX_Byte), 32'h5A);

    // ---- reset during TX bit 3
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    base_rx   = rx_cnt;
    base_done = done_cnt;
    send(8'h96);
    repeat (4 * CPB + 100) @(negedge clk);
    i_Reset = 1'b1;
    @(negedge clk);
    i_Reset = 1'b0;
    check("mrst_tx_serial", 32'(o_TX_Serial), 32'd1);
    check("mrst_tx_active", 32'(o_TX_Active), 32'd0);
    check("mrst_tx_done",   32'(o_TX_Done),   32'd0);
    check("mrst_rx_byte",   32'(o_RX_Byte),   32'h00);
    repeat (2500) @(negedge clk);
    check("mrst_no_done", 32'(done_cnt - base_done), 32'd0);
    check("mrst_no_dv", 32'(rx_cnt - base_rx), 32'd0);

    // ---- recovery round trip 0xC3
    send(8'hC3);
    wait_rx(base_rx + 1, 2300, "c3_rx_timeout");
    check("c3_rx_byte", 32'(o_RX_Byte), 32'hC3);
    wait_done(base_done + 1, 300, "c3_done_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
